// File: rtl/alu_result_collector.sv
// FWFT result FIFO with drop counter and Add/Sub accumulator; head visible the cycle after push,
// in_ready is !full from registered count. ACC_SAT_EN selects saturating (else wrapping) accumulator.
module alu_result_collector #(
  parameter int DEPTH = 8,
  parameter int ACC_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [1:0]               in_opcode,
  input  logic [4:0]               in_c,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [1:0]               out_opcode,
  output logic [4:0]               out_c,
  input  logic                     out_ready,
  input  logic                     acc_clr,
  output logic [ACC_W-1:0]         acc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] c;
  } entry_t;

  entry_t                  mem_q [DEPTH];
  entry_t                  head;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_base, acc_sum;
  logic [7:0]              drop_q, drop_d;
  logic                    push, pop, arith;

  assign full      = count_q == CW'(DEPTH);
  assign empty     = count_q == '0;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign arith     = !in_opcode[1];

  // Storage is never reset, so the head is masked while empty.
  assign head       = mem_q[rd_ptr_q];
  assign out_opcode = empty ? 2'b00 : head.op;
  assign out_c      = empty ? 5'b00000 : head.c;

  assign count    = count_q;
  assign acc      = acc_q;
  assign drop_cnt = drop_q;

  // acc_clr zeroes the base so a same-cycle arithmetic push lands on a clean accumulator.
  assign acc_base = acc_clr ? '0 : acc_q;

`ifdef ACC_SAT_EN
  logic signed [ACC_W:0] sum_wide;
  assign sum_wide = {acc_base[ACC_W-1], acc_base} + {{(ACC_W-4){in_c[4]}}, in_c};
  always_comb begin
    acc_sum = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_sum = acc_base + {{(ACC_W-5){in_c[4]}}, in_c};
`endif

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    drop_d = (in_valid && !in_ready && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    acc_d  = (push && arith) ? acc_sum : acc_base;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_opcode, in_c};
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Randomized and directed bench for alu_result_collector against a queue-based reference model.
module tb_alu_result_collector;
  localparam int DEPTH = 8;
  localparam int ACC_W = 8;
  localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
  localparam int MINV  = -(1 << (ACC_W - 1));

  typedef struct {
    int op;
    int c;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [1:0]       in_opcode;
  logic [4:0]       in_c;
  logic             in_ready;
  logic             out_valid;
  logic [1:0]       out_opcode;
  logic [4:0]       out_c;
  logic             out_ready;
  logic             acc_clr;
  logic [ACC_W-1:0] acc;
  logic [3:0]       count;
  logic             full;
  logic             empty;
  logic [7:0]       drop_cnt;

  alu_result_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode), .in_c(in_c),
    .in_ready(in_ready), .out_valid(out_valid), .out_opcode(out_opcode), .out_c(out_c),
    .out_ready(out_ready), .acc_clr(acc_clr), .acc(acc), .count(count), .full(full),
    .empty(empty), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  ent_t mq[$];
  int   macc;
  int   mdrop;
  int   n_chk;
  int   n_pass;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int fit(input int s);
    logic signed [ACC_W-1:0] t;
`ifdef ACC_SAT_EN
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
`else
    t = s[ACC_W-1:0];
    return int'(t);
`endif
  endfunction

  task automatic check_all(input string tag);
    int sz;
    sz = mq.size();
    check({tag, ".count"}, int'(count), sz);
    check({tag, ".full"}, int'(full), int'(sz == DEPTH));
    check({tag, ".empty"}, int'(empty), int'(sz == 0));
    check({tag, ".in_ready"}, int'(in_ready), int'(sz != DEPTH));
    check({tag, ".out_valid"}, int'(out_valid), int'(sz != 0));
    check({tag, ".out_opcode"}, int'(out_opcode), sz ? mq[0].op : 0);
    check({tag, ".out_c"}, int'($signed(out_c)), sz ? mq[0].c : 0);
    check({tag, ".acc"}, int'($signed(acc)), macc);
    check({tag, ".drop_cnt"}, int'(drop_cnt), mdrop);
  endtask

  // Called at a falling edge: drive inputs, advance the model, clock once, check at the next falling edge.
  task automatic cyc(input string tag, input bit v, input int op, input int c, input bit ordy, input bit clr);
    bit   pu;
    bit   po;
    int   base;
    ent_t e;
    in_valid  = v;
    in_opcode = op[1:0];
    in_c      = c[4:0];
    out_ready = ordy;
    acc_clr   = clr;
    pu = v && (mq.size() < DEPTH);
    po = ordy && (mq.size() > 0);
    if (v && !pu && mdrop < 255) mdrop++;
    if (po) e = mq.pop_front();
    if (pu) begin
      e.op = op;
      e.c  = c;
      mq.push_back(e);
    end
    base = clr ? 0 : macc;
    macc = (pu && op < 2) ? fit(base + c) : base;
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_opcode = 2'b00;
    in_c      = 5'd0;
    out_ready = 1'b0;
    acc_clr   = 1'b0;
  endtask

  initial begin
    int tp1[4];
    n_chk  = 0;
    n_pass = 0;
    macc   = 0;
    mdrop  = 0;
    idle_inputs();
    reset = 1'b1;
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Four Add pushes held, then drained in order.
    tp1 = '{14, -16, 7, -1};
    foreach (tp1[i]) cyc("tp1_push", 1'b1, 0, tp1[i], 1'b0, 1'b0);
    check("tp1_count4", int'(count), 4);
    check("tp1_acc4", int'($signed(acc)), 4);
    foreach (tp1[i]) begin
      check("tp1_head", int'($signed(out_c)), tp1[i]);
      cyc("tp1_pop", 1'b0, 0, 0, 1'b1, 1'b0);
    end
    check("tp1_empty", int'(empty), 1);

    // Fill, then hold in_valid while full.
    for (int i = 0; i < 8; i++) cyc("fill", 1'b1, 2, i - 4, 1'b0, 1'b0);
    check("fill_full", int'(full), 1);
    check("fill_in_ready", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) cyc("drop", 1'b1, 3, 1, 1'b0, 1'b0);
    check("drop3", int'(drop_cnt), 3);
    check("drop_count8", int'(count), 8);

    // Push and pop together while full: pop proceeds, push rejected.
    cyc("fullpp", 1'b1, 0, 5, 1'b1, 1'b0);
    check("fullpp_count7", int'(count), 7);
    check("fullpp_drop4", int'(drop_cnt), 4);

    // Drain to 3 entries, then stream across pointer wrap.
    for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc("stream", 1'b1, i % 4, (i * 3) % 32 - 16, 1'b1, 1'b0);
    check("stream_count3", int'(count), 3);

    // Non-arithmetic pushes leave acc; clear with Sub push loads it.
    begin
      int a0;
      a0 = int'($signed(acc));
      cyc("notA", 1'b1, 2, -1, 1'b0, 1'b0);
      cyc("rorB", 1'b1, 3, 1, 1'b0, 1'b0);
      check("nonarith_acc", int'($signed(acc)), a0);
      cyc("clr_sub", 1'b1, 1, 8, 1'b0, 1'b1);
      check("clr_sub_acc8", int'($signed(acc)), 8);
    end
    for (int i = 0; i < 6; i++) cyc("drain2", 1'b0, 0, 0, 1'b1, 1'b0);

    // Randomized traffic in phases with different consumer pressure.
    for (int i = 0; i < 400; i++) begin
      bit ordy;
      ordy = (i / 50) % 2 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cyc("rand", $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 31)) - 16, ordy, $urandom_range(0, 15) == 0);
    end

    // Drop counter saturates.
    for (int i = 0; i < 8; i++) cyc("refill", 1'b1, 2, 3, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cyc("dropsat", 1'b1, 2, 3, 1'b0, 1'b0);
    check("drop_sat255", int'(drop_cnt), 255);
    for (int i = 0; i < 8; i++) cyc("drain3", 1'b0, 0, 0, 1'b1, 1'b0);

    // Ten Add results of 14 starting from a cleared accumulator.
    cyc("acc10", 1'b1, 0, 14, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cyc("acc10", 1'b1, 0, 14, 1'b1, 1'b0);
`ifdef ACC_SAT_EN
    check("acc10_sat", int'($signed(acc)), 127);
`else
    check("acc10_wrap", int'($signed(acc)), -116);
`endif

    // Asynchronous reset mid-stream, away from any clock edge.
    cyc("prerst", 1'b1, 1, -5, 1'b0, 1'b0);
    cyc("prerst", 1'b1, 0, 9, 1'b0, 1'b0);
    idle_inputs();
    reset = 1'b1;
    #1;
    mq.delete();
    macc  = 0;
    mdrop = 0;
    check_all("midrst");
    check("midrst_acc0", int'($signed(acc)), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc("postrst", 1'b1, 0, 5, 1'b0, 1'b0);
    check("postrst_head", int'($signed(out_c)), 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
